// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: 2-entry valid/ready buffer behind the ALU plus the
// architectural {C,V,N,Z} flag register that feeds carry back to the ALU.
module alu_result_stage #(
  parameter int          WIDTH     = 16,
  parameter int          TAG_W     = 3,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_f,
  input  logic [WIDTH-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             in_negative,
  input  logic             in_zero,
  input  logic             flag_we,
  input  logic [3:0]       flag_wdata,
  output logic             qc,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  logic             accept;
  logic             pop;
  logic [3:0]       in_flags;
  logic [3:0]       flag_next;

  logic             skid_valid;
  logic [WIDTH-1:0] skid_y;
  logic [TAG_W-1:0] skid_tag;
  logic [3:0]       skid_flags;

  logic             out_valid_n;
  logic [WIDTH-1:0] out_y_n;
  logic [TAG_W-1:0] out_tag_n;
  logic [3:0]       out_flags_n;
  logic             skid_valid_n;
  logic [WIDTH-1:0] skid_y_n;
  logic [TAG_W-1:0] skid_tag_n;
  logic [3:0]       skid_flags_n;

  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign in_flags = {in_carry, in_overflow, in_negative, in_zero};
  assign qc       = flags[3];

  // Flags update when a result is accepted, so a dependent ADC/SBC issued the
  // very next cycle already sees the new carry; a direct load overrides it.
  always_comb begin
    flag_next = flags;
    if (accept) begin
      case (in_f)
        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: flag_next = in_flags;
        4'h8, 4'h9, 4'ha, 4'hb, 4'hc:       flag_next[1:0] = in_flags[1:0];
        4'hd, 4'he: begin
          flag_next[3]   = in_carry;
          flag_next[1:0] = in_flags[1:0];
        end
        default: flag_next = flags;
      endcase
    end
    if (flag_we) flag_next = flag_wdata;
  end

  // Head register is the output; the skid entry only fills while the head is stuck.
  always_comb begin
    out_valid_n  = out_valid;
    out_y_n      = out_y;
    out_tag_n    = out_tag;
    out_flags_n  = out_flags;
    skid_valid_n = skid_valid;
    skid_y_n     = skid_y;
    skid_tag_n   = skid_tag;
    skid_flags_n = skid_flags;
    if (pop || !out_valid) begin
      if (skid_valid) begin
        out_valid_n  = 1'b1;
        out_y_n      = skid_y;
        out_tag_n    = skid_tag;
        out_flags_n  = skid_flags;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        out_valid_n  = 1'b1;
        out_y_n      = in_y;
        out_tag_n    = in_tag;
        out_flags_n  = flag_next;
      end else begin
        out_valid_n  = 1'b0;
      end
    end else if (accept) begin
      skid_valid_n = 1'b1;
      skid_y_n     = in_y;
      skid_tag_n   = in_tag;
      skid_flags_n = flag_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags      <= FLAGS_RST;
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
      skid_valid <= 1'b0;
      skid_y     <= '0;
      skid_tag   <= '0;
      skid_flags <= '0;
      in_ready   <= 1'b1;
    end else begin
      flags      <= flag_next;
      out_valid  <= out_valid_n;
      out_y      <= out_y_n;
      out_tag    <= out_tag_n;
      out_flags  <= out_flags_n;
      skid_valid <= skid_valid_n;
      skid_y     <= skid_y_n;
      skid_tag   <= skid_tag_n;
      skid_flags <= skid_flags_n;
      in_ready   <= ~(out_valid_n & skid_valid_n);
    end
  end

endmodule
